// File: rtl/packet_check.sv
// Receive-side checker for the packet generator loopback path: verifies word pattern,
// word count and protocol timing per packet, then reports pass/fail and running statistics.
module packet_check #(
    parameter logic [15:0] TIMEOUT_LIMIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] length,
    input  logic        rx_start,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        rx_end,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_flags,
    output logic [15:0] mismatch_cnt,
    output logic [31:0] first_bad_idx,
    output logic [15:0] pkt_cnt,
    output logic [15:0] fail_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DATA     = 2'd1,
        ST_WAIT_END = 2'd2,
        ST_REPORT   = 2'd3
    } state_t;

    localparam logic [15:0] TO_LAST = TIMEOUT_LIMIT - 16'd1;

    localparam logic [4:0] ERR_LEN     = 5'b00001;
    localparam logic [4:0] ERR_DATA    = 5'b00010;
    localparam logic [4:0] ERR_SHORT   = 5'b00100;
    localparam logic [4:0] ERR_OVERRUN = 5'b01000;
    localparam logic [4:0] ERR_TIMEOUT = 5'b10000;

    function automatic logic [31:0] expected_word(input logic [31:0] idx);
        expected_word = {4{idx[7:0]}};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    function automatic logic length_illegal(input logic [31:0] len);
        length_illegal = (len == 32'd0) || (len[1:0] != 2'b00);
    endfunction

    state_t      state_q, state_d;
    logic [31:0] exp_words_q, exp_words_d;
    logic [31:0] idx_q, idx_d;
    logic [4:0]  wflags_q, wflags_d;
    logic [15:0] wmm_q, wmm_d;
    logic [31:0] wbad_q, wbad_d;
    logic [15:0] to_cnt_q, to_cnt_d;

    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [4:0]  err_q, err_d;
    logic [15:0] mm_out_q, mm_out_d;
    logic [31:0] bad_out_q, bad_out_d;
    logic [15:0] pkt_q, pkt_d;
    logic [15:0] fail_q, fail_d;

    logic accept_s;
    logic last_word_s;
    logic mismatch_s;
    logic timeout_s;
    logic finish_s;

    assign rx_ready      = (state_q != ST_REPORT);
    assign accept_s      = rx_valid && rx_ready;
    assign last_word_s   = (idx_q == (exp_words_q - 32'd1));
    assign mismatch_s    = (rx_data != expected_word(idx_q));
    assign timeout_s     = !accept_s && !rx_end && (to_cnt_q == TO_LAST);

    assign done          = done_q;
    assign pass          = pass_q;
    assign err_flags     = err_q;
    assign mismatch_cnt  = mm_out_q;
    assign first_bad_idx = bad_out_q;
    assign pkt_cnt       = pkt_q;
    assign fail_cnt      = fail_q;

    // Next-state logic: packet tracking, working-register updates and report capture.
    always_comb begin
        state_d     = state_q;
        exp_words_d = exp_words_q;
        idx_d       = idx_q;
        wflags_d    = wflags_q;
        wmm_d       = wmm_q;
        wbad_d      = wbad_q;
        to_cnt_d    = to_cnt_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_d       = err_q;
        mm_out_d    = mm_out_q;
        bad_out_d   = bad_out_q;
        pkt_d       = pkt_q;
        fail_d      = fail_q;
        finish_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idx_d    = 32'd0;
                wflags_d = 5'd0;
                wmm_d    = 16'd0;
                wbad_d   = 32'd0;
                to_cnt_d = 16'd0;
                if (rx_start) begin
                    exp_words_d = {2'b00, length[31:2]};
                    if (length_illegal(length)) begin
                        wflags_d = ERR_LEN;
                        finish_s = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    exp_words_d = exp_words_q;
                end
            end

            ST_DATA: begin
                if (accept_s) begin
                    idx_d    = idx_q + 32'd1;
                    to_cnt_d = 16'd0;
                    if (mismatch_s) begin
                        wflags_d = wflags_q | ERR_DATA;
                        wmm_d    = sat_inc16(wmm_q);
                        wbad_d   = wflags_q[1] ? wbad_q : idx_q;
                    end else begin
                        wflags_d = wflags_q;
                        wmm_d    = wmm_q;
                        wbad_d   = wbad_q;
                    end
                    state_d = last_word_s ? ST_WAIT_END : ST_DATA;
                end else if (rx_end) begin
                    to_cnt_d = 16'd0;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
                // A terminating event is only a short packet if the final word did not land with it.
                if (rx_start || rx_end) begin
                    finish_s = 1'b1;
                    wflags_d = wflags_d | ((accept_s && last_word_s) ? 5'd0 : ERR_SHORT);
                end else if (timeout_s) begin
                    finish_s = 1'b1;
                    wflags_d = wflags_d | ERR_TIMEOUT;
                end else begin
                    finish_s = 1'b0;
                end
            end

            ST_WAIT_END: begin
                if (accept_s) begin
                    wflags_d = wflags_q | ERR_OVERRUN;
                    to_cnt_d = 16'd0;
                end else if (rx_end) begin
                    to_cnt_d = 16'd0;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
                if (rx_start || rx_end) begin
                    finish_s = 1'b1;
                end else if (timeout_s) begin
                    finish_s = 1'b1;
                    wflags_d = wflags_d | ERR_TIMEOUT;
                end else begin
                    finish_s = 1'b0;
                end
            end

            ST_REPORT: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (finish_s) begin
            state_d   = ST_REPORT;
            done_d    = 1'b1;
            pass_d    = (wflags_d == 5'd0);
            err_d     = wflags_d;
            mm_out_d  = wmm_d;
            bad_out_d = wbad_d;
            pkt_d     = sat_inc16(pkt_q);
            fail_d    = (wflags_d != 5'd0) ? sat_inc16(fail_q) : fail_q;
        end else begin
            done_d = 1'b0;
        end
    end

    // State, working and report registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            exp_words_q <= 32'd0;
            idx_q       <= 32'd0;
            wflags_q    <= 5'd0;
            wmm_q       <= 16'd0;
            wbad_q      <= 32'd0;
            to_cnt_q    <= 16'd0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= 5'd0;
            mm_out_q    <= 16'd0;
            bad_out_q   <= 32'd0;
            pkt_q       <= 16'd0;
            fail_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            exp_words_q <= exp_words_d;
            idx_q       <= idx_d;
            wflags_q    <= wflags_d;
            wmm_q       <= wmm_d;
            wbad_q      <= wbad_d;
            to_cnt_q    <= to_cnt_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            mm_out_q    <= mm_out_d;
            bad_out_q   <= bad_out_d;
            pkt_q       <= pkt_d;
            fail_q      <= fail_d;
        end
    end

endmodule
